// File: rtl/mem_cmd_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_cmd_queue_if
//  Description : User-side command/response bundle for mem_cmd_queue.
//                master : user logic (issues commands, consumes responses)
//                slave  : the queue   (accepts commands, returns read data)
//  Signals     : cmd_valid/cmd_ready handshake, cmd_write, cmd_address,
//                cmd_wdata, rsp_valid (one-cycle pulse), rsp_data
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_cmd_queue_if #(
    parameter int AW = 26,
    parameter int DW = 128
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_address;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_write, cmd_address, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_address, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : mem_cmd_queue
//  Description : Command FIFO in front of a single-beat memory driver. Pops
//                one command at a time onto the READ/WRITE/PENDING handshake
//                and returns read data as a one-cycle response pulse.
//  Ports       : clk_i, rst_i      clock / synchronous active-high reset
//                cmd_if (slave)    command handshake and read response
//                level_o, busy_o   FIFO occupancy, activity flag
//                address_o, wdata_o, read_o, write_o   driver request
//                pending_i, rdata_i                    driver status / data
//                error_o           sticky watchdog error
//  Option      : MEM_CMD_QUEUE_WATCHDOG_EN enables the transaction watchdog
//                (TIMEOUT_CYCLES); otherwise error_o is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_cmd_queue #(
    parameter int DEPTH          = 8,
    parameter int AW             = 26,
    parameter int DW             = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire                      clk_i,
    input  wire                      rst_i,
    mem_cmd_queue_if.slave           cmd_if,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     busy_o,
    output logic [AW-1:0]            address_o,
    output logic [DW-1:0]            wdata_o,
    output logic                     read_o,
    output logic                     write_o,
    input  wire                      pending_i,
    input  wire  [DW-1:0]            rdata_i,
    output logic                     error_o
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_PTR_W = c_IDX_W + 1;
    localparam int c_ENT_W = 1 + AW + DW;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------
    logic [c_ENT_W-1:0] mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_PTR_W-1:0] w_level;
    logic               w_empty;
    logic               w_full;
    logic               w_cmd_ready;
    logic               w_push;
    logic               w_pop;
    logic [c_ENT_W-1:0] w_head;

    logic [1:0]         state_q;
    logic [1:0]         state_d;

    // Pointers carry one extra bit, so the difference is the occupancy and
    // its MSB is set exactly when the FIFO holds DEPTH entries.
    assign w_level     = wr_ptr_q - rd_ptr_q;
    assign w_empty     = (wr_ptr_q == rd_ptr_q);
    assign w_full      = w_level[c_PTR_W-1];
    // Ready comes only from registered pointers, never from a same-cycle pop.
    assign w_cmd_ready = !rst_i && !w_full;
    assign w_push      = cmd_if.cmd_valid && w_cmd_ready;
    assign w_pop       = (state_q == c_S_IDLE) && !w_empty;
    assign w_head      = mem_q[rd_ptr_q[c_IDX_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q[c_IDX_W-1:0]] <= {cmd_if.cmd_write, cmd_if.cmd_address,
                                             cmd_if.cmd_wdata};
        end
    end

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
    logic w_timeout;

`ifdef MEM_CMD_QUEUE_WATCHDOG_EN
    localparam int                c_WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

    logic [c_WD_W-1:0] wd_cnt_q;
    logic              error_q;

    // Fires on the edge where the count would reach TIMEOUT_CYCLES.
    assign w_timeout = (state_q != c_S_IDLE) && (wd_cnt_q == c_WD_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt_q <= '0;
            error_q  <= 1'b0;
        end else begin
            if (w_pop) begin
                wd_cnt_q <= '0;
            end else if (state_q != c_S_IDLE) begin
                wd_cnt_q <= wd_cnt_q + c_WD_W'(1);
            end
            if (w_timeout) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error_o = error_q;
`else
    assign w_timeout = 1'b0;
    assign error_o   = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    logic [AW-1:0] addr_q,     addr_d;
    logic [DW-1:0] wdata_q,    wdata_d;
    logic          is_write_q, is_write_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q,  rsp_data_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= c_S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            is_write_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            is_write_q  <= is_write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_write_d  = is_write_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            c_S_IDLE: begin
                if (!w_empty) begin
                    addr_d     = w_head[DW +: AW];
                    wdata_d    = w_head[DW-1:0];
                    is_write_d = w_head[c_ENT_W-1];
                    state_d    = c_S_ISSUE;
                end
            end
            c_S_ISSUE: begin
                if (w_timeout) begin
                    state_d = c_S_IDLE;
                end else if (pending_i) begin
                    state_d = c_S_WAIT;
                end
            end
            c_S_WAIT: begin
                if (w_timeout) begin
                    state_d = c_S_IDLE;
                end else if (!pending_i) begin
                    if (!is_write_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rdata_i;
                    end
                    state_d = c_S_IDLE;
                end
            end
            default: begin
                state_d = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        read_o  = 1'b0;
        write_o = 1'b0;
        if (state_q == c_S_ISSUE) begin
            read_o  = !is_write_q;
            write_o = is_write_q;
        end
        busy_o = (state_q != c_S_IDLE) || !w_empty;
    end

    assign level_o          = w_level;
    assign address_o        = addr_q;
    assign wdata_o          = wdata_q;
    assign cmd_if.cmd_ready = w_cmd_ready;
    assign cmd_if.rsp_valid = rsp_valid_q;
    assign cmd_if.rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_cmd_queue
//  Description : Self-checking bench for mem_cmd_queue. A queue-based model
//                predicts every output each cycle; directed tests add
//                hand-computed expectations. Watchdog test runs only when
//                MEM_CMD_QUEUE_WATCHDOG_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_cmd_queue;

    localparam int DEPTH   = 8;
    localparam int AW      = 26;
    localparam int DW      = 128;
    localparam int TIMEOUT = 16;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LW-1:0] level;
    logic          busy, read, write, error, pending;
    logic [AW-1:0] address;
    logic [DW-1:0] wdata, rdata;

    always #5 clk = ~clk;

    mem_cmd_queue_if #(.AW(AW), .DW(DW)) cmd_if ();

    mem_cmd_queue #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .cmd_if    (cmd_if),
        .level_o   (level),
        .busy_o    (busy),
        .address_o (address),
        .wdata_o   (wdata),
        .read_o    (read),
        .write_o   (write),
        .pending_i (pending),
        .rdata_i   (rdata),
        .error_o   (error)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s wait bound expired at %0t", name, $time);
    endtask

    // ------------------------------------------------------------------------
    // Driver model: raises PENDING as soon as a strobe is seen, lowers it
    // drv_hold cycles later (or never while hold_forever), returns memory data.
    // ------------------------------------------------------------------------
    logic [DW-1:0] drv_mem [logic [AW-1:0]];
    bit            drv_active   = 0;
    bit            hold_forever = 0;
    int            drv_hold     = 3;
    int            drv_cnt      = 0;
    logic [AW-1:0] drv_addr;
    bit            drv_w;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return drv_mem.exists(a) ? drv_mem[a] : '0;
    endfunction

    initial begin
        pending = 1'b0;
        rdata   = '0;
    end

    always @(negedge clk) begin
        if (rst) begin
            pending    = 1'b0;
            drv_active = 0;
        end else if (drv_active) begin
            if (!hold_forever) begin
                if (drv_cnt <= 1) begin
                    pending    = 1'b0;
                    drv_active = 0;
                    if (!drv_w) rdata = mem_rd(drv_addr);
                end else begin
                    drv_cnt--;
                end
            end
        end else if (read || write) begin
            drv_active = 1;
            drv_addr   = address;
            drv_w      = write;
            drv_cnt    = drv_hold;
            pending    = 1'b1;
            if (write) drv_mem[address] = wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Behavioural model: command queue plus the single transaction in flight.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;

    cmd_t          mq[$];
    cmd_t          mcur, nc;
    int            mphase;   // 0 idle, 1 strobing, 2 waiting for completion
    int            mcnt;
    bit            m_valid = 0;
    bit            m_push, m_tmo;
    logic          m_rspv, m_err;
    logic [DW-1:0] m_rspd, m_wdata;
    logic [AW-1:0] m_addr;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mphase  = 0;
            mcnt    = 0;
            m_rspv  = 0;
            m_rspd  = '0;
            m_err   = 0;
            m_addr  = '0;
            m_wdata = '0;
            mcur    = '0;
            m_valid = 1;
        end else begin
            m_push = cmd_if.cmd_valid && (mq.size() < DEPTH);
            nc.w   = cmd_if.cmd_write;
            nc.a   = cmd_if.cmd_address;
            nc.d   = cmd_if.cmd_wdata;
            m_rspv = 0;
            m_tmo  = 0;
            if (mphase != 0) begin
                mcnt++;
`ifdef MEM_CMD_QUEUE_WATCHDOG_EN
                if (mcnt == TIMEOUT) m_tmo = 1;
`endif
            end
            case (mphase)
                0: if (mq.size() > 0) begin
                    mcur    = mq.pop_front();
                    m_addr  = mcur.a;
                    m_wdata = mcur.d;
                    mphase  = 1;
                    mcnt    = 0;
                end
                1: if (m_tmo) begin
                    m_err = 1; mphase = 0;
                end else if (pending) begin
                    mphase = 2;
                end
                default: if (m_tmo) begin
                    m_err = 1; mphase = 0;
                end else if (!pending) begin
                    if (!mcur.w) begin
                        m_rspv = 1;
                        m_rspd = rdata;
                    end
                    mphase = 0;
                end
            endcase
            if (m_push) mq.push_back(nc);
        end
    end

    // Compare process: every output, every cycle, against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cmd_ready", 128'(cmd_if.cmd_ready), 128'(!rst && (mq.size() < DEPTH)));
            check("level",     128'(level),    128'(mq.size()));
            check("busy",      128'(busy),     128'(mphase != 0 || mq.size() > 0));
            check("read",      128'(read),     128'(mphase == 1 && !mcur.w));
            check("write",     128'(write),    128'(mphase == 1 && mcur.w));
            check("address",   128'(address),  128'(m_addr));
            check("wdata",     128'(wdata),    128'(m_wdata));
            check("rsp_valid", 128'(cmd_if.rsp_valid), 128'(m_rspv));
            check("rsp_data",  128'(cmd_if.rsp_data),  128'(m_rspd));
            check("error",     128'(error),    128'(m_err));
        end
    end

    // Logs of strobe starts and responses for the directed tests.
    logic [AW:0]   strobe_log[$];
    logic [DW-1:0] rsp_log[$];
    bit            prev_strobe = 0;
    int            read_hi     = 0;

    always @(negedge clk) begin
        if ((read || write) && !prev_strobe) strobe_log.push_back({write, address});
        prev_strobe = read || write;
        if (read) read_hi++;
        if (cmd_if.rsp_valid) rsp_log.push_back(cmd_if.rsp_data);
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (called just after a falling edge)
    // ------------------------------------------------------------------------
    task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int b;
        b = 0;
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_write   = w;
        cmd_if.cmd_address = a;
        cmd_if.cmd_wdata   = d;
        while (!cmd_if.cmd_ready && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (b >= 300) bound_fail("push");
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((busy || pending) && b < 500) begin
            @(negedge clk);
            b++;
        end
        if (b >= 500) bound_fail("wait_idle");
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    int bs, br, bh, k;

    initial begin
        cmd_if.cmd_valid   = 1'b0;
        cmd_if.cmd_write   = 1'b0;
        cmd_if.cmd_address = '0;
        cmd_if.cmd_wdata   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_level", 128'(level), 128'd0);
        check("rst_busy",  128'(busy),  128'd0);
        check("rst_strobe", 128'({read, write}), 128'd0);
        check("rst_rsp",   128'({cmd_if.rsp_valid, cmd_if.rsp_data}), 128'd0);
        check("rst_addr",  128'(address), 128'd0);
        check("rst_error", 128'(error), 128'd0);
        check("rst_ready", 128'(cmd_if.cmd_ready), 128'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 128'(cmd_if.cmd_ready), 128'd1);

        // Single read
        drv_mem[26'h0000100] = 128'hDEAD_BEEF;
        bs = strobe_log.size(); br = rsp_log.size(); bh = read_hi;
        push(1'b0, 26'h0000100, '0);
        check("lat_read_low", 128'(read), 128'd0);
        @(negedge clk);
        check("lat_read_high", 128'(read), 128'd1);
        check("lat_addr", 128'(address), 128'h0000100);
        wait_idle();
        check("sr_read_cycles", 128'(read_hi - bh), 128'd1);
        check("sr_strobes", 128'(strobe_log.size() - bs), 128'd1);
        check("sr_rsp_count", 128'(rsp_log.size() - br), 128'd1);
        if (rsp_log.size() > br) check("sr_rsp_data", rsp_log[br], 128'hDEAD_BEEF);
        check("sr_level", 128'(level), 128'd0);

        // Write then read
        bs = strobe_log.size(); br = rsp_log.size();
        push(1'b1, 26'h10, 128'h1234);
        push(1'b0, 26'h10, '0);
        wait_idle();
        check("wr_strobes", 128'(strobe_log.size() - bs), 128'd2);
        if (strobe_log.size() >= bs + 2) begin
            check("wr_first",  128'(strobe_log[bs]),     128'({1'b1, 26'h10}));
            check("wr_second", 128'(strobe_log[bs + 1]), 128'({1'b0, 26'h10}));
        end
        check("wr_rsp_count", 128'(rsp_log.size() - br), 128'd1);
        if (rsp_log.size() > br) check("wr_rsp_data", rsp_log[br], 128'h1234);

        // Full queue
        bs = strobe_log.size();
        hold_forever = 1;
        for (int i = 0; i < 8; i++) push(1'b0, AW'(32'h200 + i), '0);
        check("full_level7", 128'(level), 128'd7);
        push(1'b0, 26'h208, '0);
        check("full_level8", 128'(level), 128'd8);
        check("full_ready", 128'(cmd_if.cmd_ready), 128'd0);
        fork
            push(1'b0, 26'h209, '0);
            begin
                repeat (4) @(negedge clk);
                check("full_blocked_level", 128'(level), 128'd8);
                check("full_blocked_ready", 128'(cmd_if.cmd_ready), 128'd0);
                hold_forever = 0;
            end
        join
        wait_idle();
        check("full_strobes", 128'(strobe_log.size() - bs), 128'd10);
        for (int i = 0; i < 10; i++)
            if (strobe_log.size() > bs + i)
                check("full_order", 128'(strobe_log[bs + i]), 128'({1'b0, AW'(32'h200 + i)}));
        check("full_level0", 128'(level), 128'd0);

        // Pointer wrap: 20 sequential reads
        bs = strobe_log.size(); br = rsp_log.size();
        for (int i = 0; i < 20; i++) drv_mem[AW'(i)] = 128'hC0DE_0000 + 128'(i);
        for (int i = 0; i < 20; i++) push(1'b0, AW'(i), '0);
        wait_idle();
        check("wrap_strobes", 128'(strobe_log.size() - bs), 128'd20);
        check("wrap_rsps", 128'(rsp_log.size() - br), 128'd20);
        for (int i = 0; i < 20; i++) begin
            if (strobe_log.size() > bs + i)
                check("wrap_addr", 128'(strobe_log[bs + i]), 128'({1'b0, AW'(i)}));
            if (rsp_log.size() > br + i)
                check("wrap_data", rsp_log[br + i], 128'hC0DE_0000 + 128'(i));
        end

        // Reset mid-transaction
        hold_forever = 1;
        for (int i = 0; i < 4; i++) push(1'b0, AW'(32'h300 + i), '0);
        check("mid_level3", 128'(level), 128'd3);
        check("mid_pending", 128'(pending), 128'd1);
        br = rsp_log.size();
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_level", 128'(level), 128'd0);
        check("mid_rst_strobe", 128'({read, write}), 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_error", 128'(error), 128'd0);
        #1 rst = 1'b0;
        hold_forever = 0;
        repeat (6) @(negedge clk);
        check("mid_no_rsp", 128'(rsp_log.size() - br), 128'd0);
        check("mid_idle", 128'(busy), 128'd0);

`ifdef MEM_CMD_QUEUE_WATCHDOG_EN
        // Watchdog
        hold_forever = 1;
        br = rsp_log.size();
        push(1'b0, 26'h400, '0);
        push(1'b0, 26'h401, '0);
        k = 0;
        while (!read && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) bound_fail("wd_first_strobe");
        k = 0;
        while (!error && k < 100) begin @(negedge clk); k++; end
        if (k >= 100) bound_fail("wd_error");
        check("wd_latency", 128'(k), 128'd16);
        @(negedge clk);
        check("wd_next_read", 128'(read), 128'd1);
        check("wd_next_addr", 128'(address), 128'h401);
        repeat (5) @(negedge clk);
        check("wd_sticky", 128'(error), 128'd1);
        check("wd_no_rsp", 128'(rsp_log.size() - br), 128'd0);
        hold_forever = 0;
        pulse_reset();
        @(negedge clk);
        check("wd_cleared", 128'(error), 128'd0);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
